// File: rtl/i2c_reg_pkg.sv
// Shared constants for the redriver register bank: register map, CTRL bit positions,
// write-FSM encoding and reset values.
package i2c_reg_pkg;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h23;
  localparam logic [7:0] DEF_CHIP_ID  = 8'hA0;

  localparam int NUM_CH   = 4;
  localparam int EQ_W     = 4;
  localparam int EQ_OUT_W = NUM_CH * EQ_W;

  localparam logic [7:0] OFS_CHIP_ID  = 8'h00;
  localparam logic [7:0] OFS_CTRL     = 8'h01;
  localparam logic [7:0] OFS_STATUS   = 8'h02;
  localparam logic [7:0] OFS_IRQ_MASK = 8'h03;
  localparam logic [7:0] OFS_EQ_SH0   = 8'h10;
  localparam logic [7:0] OFS_EQ_SH3   = 8'h13;
  localparam logic [7:0] OFS_CHEN_SH  = 8'h14;

  localparam int CTRL_LOCK_BIT   = 0;
  localparam int CTRL_COMMIT_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [7:0] ofs;
    logic [7:0] data;
  } wr_req_t;

  localparam logic                RST_LOCK     = 1'b0;
  localparam logic [NUM_CH-1:0]   RST_IRQ_MASK = '0;
  localparam logic [EQ_W-1:0]     RST_EQ_SH    = '0;
  localparam logic [NUM_CH-1:0]   RST_CHEN     = '0;
  localparam logic [EQ_OUT_W-1:0] RST_EQ_OUT   = '0;
  localparam logic [7:0]          RST_TX_DATA  = 8'h00;

  function automatic logic is_eq_sh(input logic [7:0] ofs);
    return (ofs >= OFS_EQ_SH0) && (ofs <= OFS_EQ_SH3);
  endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Byte-level handshake between i2c_slave (master side) and the register bank (slave side).
interface i2c_reg_bank_if;
  logic [7:0] rx_address;
  logic [7:0] rx_offset;
  logic [7:0] rx_data;
  logic       iwrite_en;
  logic       iread_en;
  logic [7:0] tx_data;

  modport master (
    output rx_address, rx_offset, rx_data, iwrite_en, iread_en,
    input  tx_data
  );

  modport slave (
    input  rx_address, rx_offset, rx_data, iwrite_en, iread_en,
    output tx_data
  );
endinterface

// File: rtl/los_sticky_latch.sv
// Synchronises the asynchronous loss-of-signal inputs and holds them as sticky bits
// that a STATUS read clears; a bit still asserted in the clearing cycle stays set.
module los_sticky_latch
  import i2c_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] los_async_i,
  input  logic              clr_i,
  output logic [NUM_CH-1:0] status_o
);

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  always_comb sticky_d = (clr_i ? '0 : sticky_q) | sync2_q;

  // NOTE: state is assigned with <= so every flop samples pre-edge values,
  // which is what makes the two synchroniser stages a real two-cycle delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sticky_q <= '0;
    end else begin
      sync1_q  <= los_async_i;
      sync2_q  <= sync1_q;
      sticky_q <= sticky_d;
    end
  end

  assign status_o = sticky_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind i2c_slave. EQ and channel-enable writes land in shadows and
// reach the redriver outputs together when CTRL.COMMIT is written.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter logic [7:0] CHIP_ID  = DEF_CHIP_ID
) (
  input  logic                SYSTEM_CLK,
  input  logic                RESETn,
  i2c_reg_bank_if.slave       bus,
  input  logic [NUM_CH-1:0]   los_in,
  output logic [EQ_OUT_W-1:0] eq_ctrl,
  output logic [NUM_CH-1:0]   ch_enable,
  output logic                irq
);

  logic wr_prev_q, rd_prev_q;
  logic wr_rise, rd_rise, addr_match, status_clr;

  logic    pend_q;
  wr_req_t pend_req_q;
  wr_req_t work_q;

  wr_state_e                      state_q;
  logic                           lock_q;
  logic [NUM_CH-1:0]              irq_mask_q;
  logic [NUM_CH-1:0][EQ_W-1:0]    eq_sh_q;
  logic [NUM_CH-1:0]              chen_sh_q;
  logic [EQ_OUT_W-1:0]            eq_ctrl_q;
  logic [NUM_CH-1:0]              ch_enable_q;
  logic                           irq_q;
  logic [7:0]                     tx_data_q, tx_data_d;
  logic [NUM_CH-1:0]              status;

  assign addr_match = (bus.rx_address[7:1] == DEV_ADDR);
  assign wr_rise    = bus.iwrite_en & ~wr_prev_q;
  assign rd_rise    = bus.iread_en & ~rd_prev_q;
  assign status_clr = rd_rise & addr_match & (bus.rx_offset == OFS_STATUS);

  // A write edge is captured into a one-deep pending slot so that bytes arriving
  // while the FSM is busy are serviced once it is back in IDLE.
  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_req_q <= '0;
    end else begin
      wr_prev_q <= bus.iwrite_en;
      rd_prev_q <= bus.iread_en;
      if (wr_rise && addr_match) begin
        pend_q     <= 1'b1;
        pend_req_q <= '{ofs: bus.rx_offset, data: bus.rx_data};
      end else if (state_q == ST_IDLE) begin
        pend_q <= 1'b0;
      end
    end
  end

  // NOTE: the shadow and output registers are reset explicitly; a reset during
  // COMMIT must leave no half-copied equaliser setting behind.
  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      lock_q      <= RST_LOCK;
      irq_mask_q  <= RST_IRQ_MASK;
      eq_sh_q     <= {NUM_CH{RST_EQ_SH}};
      chen_sh_q   <= RST_CHEN;
      eq_ctrl_q   <= RST_EQ_OUT;
      ch_enable_q <= RST_CHEN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            work_q  <= pend_req_q;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (work_q.ofs == OFS_CTRL) begin
            lock_q <= work_q.data[CTRL_LOCK_BIT];
          end else if (work_q.ofs == OFS_IRQ_MASK) begin
            irq_mask_q <= work_q.data[NUM_CH-1:0];
          end else if (is_eq_sh(work_q.ofs) && !lock_q) begin
            eq_sh_q[work_q.ofs[1:0]] <= work_q.data[EQ_W-1:0];
          end else if ((work_q.ofs == OFS_CHEN_SH) && !lock_q) begin
            chen_sh_q <= work_q.data[NUM_CH-1:0];
          end
          state_q <= ((work_q.ofs == OFS_CTRL) && work_q.data[CTRL_COMMIT_BIT])
                     ? ST_COMMIT : ST_IDLE;
        end
        ST_COMMIT: begin
          eq_ctrl_q   <= eq_sh_q;
          ch_enable_q <= chen_sh_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  los_sticky_latch u_los (
    .clk         (SYSTEM_CLK),
    .rst_n       (RESETn),
    .los_async_i (los_in),
    .clr_i       (status_clr),
    .status_o    (status)
  );

  // NOTE: tx_data_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_data_d = RST_TX_DATA;
    if (addr_match) begin
      if (is_eq_sh(bus.rx_offset)) begin
        tx_data_d[EQ_W-1:0] = eq_sh_q[bus.rx_offset[1:0]];
      end else begin
        case (bus.rx_offset)
          OFS_CHIP_ID:  tx_data_d = CHIP_ID;
          OFS_CTRL:     tx_data_d[CTRL_LOCK_BIT] = lock_q;
          OFS_STATUS:   tx_data_d[NUM_CH-1:0] = status;
          OFS_IRQ_MASK: tx_data_d[NUM_CH-1:0] = irq_mask_q;
          OFS_CHEN_SH:  tx_data_d[NUM_CH-1:0] = chen_sh_q;
          default:      tx_data_d = RST_TX_DATA;
        endcase
      end
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      tx_data_q <= RST_TX_DATA;
      irq_q     <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      irq_q     <= |(status & irq_mask_q);
    end
  end

  assign bus.tx_data = tx_data_q;
  assign eq_ctrl     = eq_ctrl_q;
  assign ch_enable   = ch_enable_q;
  assign irq         = irq_q;

  // R/W bit and the unmapped CTRL data bits carry no state.
  logic unused_bits;
  assign unused_bits = ^{bus.rx_address[0], work_q.data[6:4]};

endmodule

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Register bank sitting directly downstream of `i2c_slave` in the redriver controller.
- Consumes the slave's address, offset and data bytes and its write/read strobes.
- Returns read data on `tx_data`.
- Drives the redriver's per-channel equaliser and channel-enable controls through a shadow/commit scheme, so updates apply atomically.
- Latches loss-of-signal status as sticky, clear-on-read bits and raises a maskable interrupt.

## Interface
- `DEV_ADDR`, 7'h23: 7-bit device address. It matches the address byte 8'h46/8'h47.
- `CHIP_ID`, 8'hA0: value returned at offset 0x00.
- `SYSTEM_CLK` in 1: single clock for all logic.
- `RESETn` in 1: reset, asynchronous assert, active-low.
- `rx_address` in 8: address byte from the slave. Bits [7:1] are the address; bit 0 is R/W.
- `rx_offset` in 8: register offset from the slave.
- `rx_data` in 8: write data byte from the slave.
- `iwrite_en` in 1: slave write strobe (the slave's `owrite_en`). Level signal that may stay high for several cycles.
- `iread_en` in 1: slave read strobe (the slave's `oread_en`). Level signal.
- `los_in` in 4: per-channel loss-of-signal. Asynchronous to `SYSTEM_CLK`.
- `tx_data` out 8: read data to the slave.
- `eq_ctrl` out 16: active equaliser setting, 4 bits per channel; channel n is bits [4n+3:4n].
- `ch_enable` out 4: active channel enables.
- `irq` out 1: interrupt, active-high.

## Operation
- Register map:
  - 0x00 CHIP_ID: read-only.
  - 0x01 CTRL: bit0 LOCK (RW); bit7 COMMIT (write-1, self-clearing, always reads 0).
  - 0x02 STATUS: [3:0] sticky LOS, read-only, cleared on read.
  - 0x03 IRQ_MASK: [3:0] RW.
  - 0x10–0x13 EQ_SH0..3: [3:0] RW shadow.
  - 0x14 CHEN_SH: [3:0] RW shadow.
  - Unused bits read 0. Unmapped offsets read 8'h00; writes to them are ignored.
- Address match: `rx_address[7:1] == DEV_ADDR`. On mismatch, writes are ignored, reads do not clear STATUS, and `tx_data` = 8'h00.
- Write FSM states: IDLE, WRITE, COMMIT.
  - IDLE → WRITE on a rising edge of `iwrite_en` (previous sample 0, current 1). `rx_offset` and `rx_data` are latched on that edge.
  - WRITE updates the addressed register. It then goes to COMMIT if offset = 0x01 and data bit7 = 1; otherwise back to IDLE.
  - COMMIT copies EQ_SH0..3 → `eq_ctrl` and CHEN_SH → `ch_enable`, then returns to IDLE.
- LOCK = 1 blocks writes to 0x10–0x14. Those writes are dropped. COMMIT still works and copies the existing shadows.
- A level held high counts as one event. A new event requires `iwrite_en`/`iread_en` to fall first.
- STATUS path:
  - `los_in` passes through a 2-flop synchroniser.
  - A sticky bit sets when its synchronised bit is 1.
  - A rising edge of `iread_en` with address match and `rx_offset` = 0x02 clears STATUS.
  - If set and clear occur in the same cycle, set wins.
- `irq` = registered OR of (STATUS & IRQ_MASK).

## Timing
- All outputs are reset to 0: `tx_data`, `eq_ctrl`, `ch_enable`, `irq`. CTRL, IRQ_MASK, shadows and STATUS also reset to 0. FSM resets to IDLE.
- Write latency, counted from the edge-detect cycle:
  - Register is updated 2 cycles after the edge.
  - Outputs change 3 cycles after a commit write.
- `tx_data` is a registered mux of `rx_offset`, updated every cycle: 1-cycle latency from an offset change.
- `irq` follows a `los_in` change by at most 4 cycles: 2 synchroniser, 1 sticky, 1 irq register.
- `iwrite_en` edges arriving while the FSM is in WRITE or COMMIT are still detected and serviced when the FSM returns to IDLE. One pending event is held; the slave guarantees ≥8 cycles between bytes.
- Reset asserted mid-write or mid-commit: everything returns to reset values immediately. No partial commit may remain visible after reset.

## Structure
- Package `i2c_reg_pkg` holds:
  - offset constants (`OFS_CHIP_ID`, `OFS_CTRL`, `OFS_STATUS`, `OFS_IRQ_MASK`, `OFS_EQ_SH0`, `OFS_CHEN_SH`);
  - CTRL bit indices;
  - FSM state encoding;
  - reset values.
- One sub-module, `los_sticky_latch`, contains the 2-flop synchroniser, sticky set, clear-on-read and set-priority logic for 4 bits.

## Test plan
- Reset, then read 0x00 with `rx_address` = 8'h47 → `tx_data` = 8'hA0 one cycle after the offset is applied. All outputs are 0 during reset.
- Write 0x10=8'h05, 0x14=8'h0F, then 0x01=8'h80 → `eq_ctrl` stays 0 until 3 cycles after the commit edge, then `eq_ctrl[3:0]`=4'h5 and `ch_enable`=4'hF. CTRL reads 8'h00.
- Write 0x01=8'h01 (LOCK), then 0x11=8'h07, then commit → `eq_ctrl[7:4]` stays 0. Reading 0x11 returns 8'h00.
- Pulse `los_in[2]` for 1 µs with IRQ_MASK=8'h04 → STATUS reads 8'h04 and `irq`=1. A second read of 0x02 returns 8'h00 and `irq` falls. Repeat with `los_in[2]` held high → the bit stays set after the read.
- Write with `rx_address`=8'h48 → no register change, and `tx_data`=8'h00.
- `iwrite_en` held high 20 cycles with 0x03=8'h0F → exactly one write. Assert `RESETn` low during COMMIT → `eq_ctrl`=0 and no update after release.
